// File: rtl/subneg_mem_responder.sv
// Far-side memory responder for the SUBNEG bus: address latch, byte SRAM, output latch, host load port.
// Define OUT_FIFO_EN to replace the single output register with an OUT_DEPTH-entry FIFO.
module subneg_mem_responder #(
    parameter int AW        = 8,
    parameter int OUT_DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          bus_latch_clk,
    input  logic          bus_oe,
    input  logic          bus_we,
    input  logic          bus_out_clk,
    input  logic [7:0]    bus_data_in,
    output logic [7:0]    bus_data_out,
    output logic          bus_data_oe,
    input  logic          load_valid,
    output logic          load_ready,
    input  logic [AW-1:0] load_addr,
    input  logic [7:0]    load_data,
    output logic [7:0]    out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [7:0]    out_count
);

    localparam int DEPTH = 1 << AW;

    logic [AW-1:0] addr_q, addr_d;
    logic          latch_p_q, latch_p_d;
    logic          we_p_q, we_p_d;
    logic          out_p_q, out_p_d;
    logic [7:0]    out_count_q, out_count_d;
    logic          latch_rise, we_fall, out_rise;
    logic [7:0]    mem [DEPTH];

    // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        latch_rise  = bus_latch_clk & ~latch_p_q;
        we_fall     = ~bus_we & we_p_q;
        out_rise    = bus_out_clk & ~out_p_q;
        latch_p_d   = bus_latch_clk;
        we_p_d      = bus_we;
        out_p_d     = bus_out_clk;
        addr_d      = addr_q;
        out_count_d = out_count_q;
        if (latch_rise) addr_d = bus_data_in[AW-1:0];
        if (out_rise)   out_count_d = out_count_q + 8'd1;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q      <= '0;
            latch_p_q   <= 1'b1;
            we_p_q      <= 1'b1;
            out_p_q     <= 1'b1;
            out_count_q <= 8'd0;
        end else begin
            addr_q      <= addr_d;
            latch_p_q   <= latch_p_d;
            we_p_q      <= we_p_d;
            out_p_q     <= out_p_d;
            out_count_q <= out_count_d;
        end
    end

    assign load_ready = ~we_fall;

    // NOTE: storage arrays carry no reset; only control state is cleared, so the array maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (we_fall) begin
            mem[addr_q] <= bus_data_in;
        end else if (load_valid && load_ready) begin
            mem[load_addr] <= load_data;
        end
    end

    assign bus_data_oe  = ~bus_oe;
    assign bus_data_out = bus_data_oe ? mem[addr_q] : 8'h00;
    assign out_count    = out_count_q;

`ifdef OUT_FIFO_EN
    localparam int PW = $clog2(OUT_DEPTH);

    logic [7:0]  fifo_mem [OUT_DEPTH];
    logic [PW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic        fifo_empty, fifo_full, push, pop;

    // Pointers carry one extra wrap bit to tell full from empty.
    always_comb begin
        fifo_empty = (wr_ptr_q == rd_ptr_q);
        fifo_full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
        pop        = ~fifo_empty & out_ready;
        push       = out_rise & (~fifo_full | pop);
        wr_ptr_d   = wr_ptr_q + {{PW{1'b0}}, push};
        rd_ptr_d   = rd_ptr_q + {{PW{1'b0}}, pop};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_q[PW-1:0]] <= bus_data_in;
    end

    assign out_valid = ~fifo_empty;
    assign out_data  = fifo_empty ? 8'h00 : fifo_mem[rd_ptr_q[PW-1:0]];
`else
    logic [7:0] out_data_q, out_data_d;
    logic       out_valid_q, out_valid_d;
    logic       unused_out_ready;

    assign unused_out_ready = out_ready;

    always_comb begin
        out_data_d  = out_data_q;
        out_valid_d = out_rise;
        if (out_rise) out_data_d = bus_data_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_q  <= 8'h00;
            out_valid_q <= 1'b0;
        end else begin
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
`endif

endmodule

// File: tb/tb_subneg_mem_responder.sv
// Directed bench for subneg_mem_responder: a vector table for the main flow plus hand sequences
// for the narrow-address instance and (when OUT_FIFO_EN is defined) the output FIFO.
module tb_subneg_mem_responder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       bus_latch_clk, bus_oe, bus_we, bus_out_clk;
    logic [7:0] bus_data_in, bus_data_out;
    logic       bus_data_oe, load_valid, load_ready;
    logic [7:0] load_addr, load_data, out_data, out_count;
    logic       out_valid, out_ready;

    logic       a4_lc, a4_oe, a4_we, a4_oc, a4_lv, a4_lr, a4_doe, a4_ov, a4_ordy;
    logic [7:0] a4_din, a4_dout, a4_ld, a4_od, a4_cnt;
    logic [3:0] a4_la;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    subneg_mem_responder #(.AW(8), .OUT_DEPTH(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .bus_latch_clk(bus_latch_clk), .bus_oe(bus_oe),
        .bus_we(bus_we), .bus_out_clk(bus_out_clk), .bus_data_in(bus_data_in),
        .bus_data_out(bus_data_out), .bus_data_oe(bus_data_oe), .load_valid(load_valid),
        .load_ready(load_ready), .load_addr(load_addr), .load_data(load_data),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_count(out_count)
    );

    subneg_mem_responder #(.AW(4), .OUT_DEPTH(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .bus_latch_clk(a4_lc), .bus_oe(a4_oe),
        .bus_we(a4_we), .bus_out_clk(a4_oc), .bus_data_in(a4_din),
        .bus_data_out(a4_dout), .bus_data_oe(a4_doe), .load_valid(a4_lv),
        .load_ready(a4_lr), .load_addr(a4_la), .load_data(a4_ld),
        .out_data(a4_od), .out_valid(a4_ov), .out_ready(a4_ordy), .out_count(a4_cnt)
    );

    // Output data while idle: held register in the default build, 0 for an empty FIFO.
`ifdef OUT_FIFO_EN
    localparam logic [7:0] H5A = 8'h00, HA5 = 8'h00, H01 = 8'h00;
`else
    localparam logic [7:0] H5A = 8'h5A, HA5 = 8'hA5, H01 = 8'h01;
`endif

    localparam logic [2:0] MR = 3'b001, ML = 3'b010, MO = 3'b100;

    typedef struct {
        logic       rst, lc, oe, we, oc, lv;
        logic [7:0] din, la, ld;
        logic [2:0] mask;
        logic [7:0] e_dout;
        logic       e_lr;
        logic [7:0] e_od;
        logic       e_ov;
        logic [7:0] e_oc;
    } vec_t;

    vec_t tbl[$];

    task automatic v(input logic rst, lc, oe, we, oc, input logic [7:0] din,
                     input logic lv, input logic [7:0] la, ld, input logic [2:0] m,
                     input logic [7:0] ed, input logic elr, input logic [7:0] eod,
                     input logic eov, input logic [7:0] eoc);
        vec_t x;
        x.rst = rst; x.lc = lc; x.oe = oe; x.we = we; x.oc = oc; x.din = din;
        x.lv = lv; x.la = la; x.ld = ld; x.mask = m; x.e_dout = ed; x.e_lr = elr;
        x.e_od = eod; x.e_ov = eov; x.e_oc = eoc;
        tbl.push_back(x);
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

`ifdef OUT_FIFO_EN
    task automatic out_edge(input logic [7:0] b);
        bus_out_clk = 1'b1; bus_data_in = b;
        tick();
        bus_out_clk = 1'b0;
        tick();
    endtask
`endif

    initial begin
        //  rst lc oe we oc din    lv la     ld     mask      dout  lr od     ov oc
        v(0, 0, 1, 1, 0, 8'h00, 0, 8'h00, 8'h00, MR|ML|MO, 8'h00, 1, 8'h00, 0, 8'd0); // 0 reset
        v(1, 0, 1, 1, 0, 8'h00, 0, 8'h00, 8'h00, MR|ML|MO, 8'h00, 1, 8'h00, 0, 8'd0);
        v(1, 0, 1, 1, 0, 8'h00, 1, 8'h00, 8'h0A, ML,       8'h00, 1, 8'h00, 0, 8'd0); // 2 loads
        v(1, 0, 1, 1, 0, 8'h00, 1, 8'h01, 8'h0B, ML,       8'h00, 1, 8'h00, 0, 8'd0);
        v(1, 0, 1, 1, 0, 8'h00, 1, 8'h02, 8'h14, ML,       8'h00, 1, 8'h00, 0, 8'd0);
        v(1, 0, 1, 1, 0, 8'h00, 1, 8'h0A, 8'h03, ML,       8'h00, 1, 8'h00, 0, 8'd0);
        v(1, 0, 1, 1, 0, 8'h00, 1, 8'h0B, 8'h07, ML,       8'h00, 1, 8'h00, 0, 8'd0);
        v(1, 1, 1, 1, 0, 8'h02, 0, 8'h00, 8'h00, MR,       8'h00, 1, 8'h00, 0, 8'd0); // 7 fetches
        v(1, 0, 0, 1, 0, 8'h00, 0, 8'h00, 8'h00, MR,       8'h14, 1, 8'h00, 0, 8'd0);
        v(1, 1, 1, 1, 0, 8'h00, 0, 8'h00, 8'h00, MR,       8'h00, 1, 8'h00, 0, 8'd0);
        v(1, 0, 0, 1, 0, 8'h00, 0, 8'h00, 8'h00, MR,       8'h0A, 1, 8'h00, 0, 8'd0);
        v(1, 1, 1, 1, 0, 8'h0B, 0, 8'h00, 8'h00, MR,       8'h00, 1, 8'h00, 0, 8'd0);
        v(1, 0, 0, 1, 0, 8'h00, 0, 8'h00, 8'h00, MR,       8'h07, 1, 8'h00, 0, 8'd0);
        v(1, 1, 0, 1, 0, 8'h01, 0, 8'h00, 8'h00, MR,       8'h07, 1, 8'h00, 0, 8'd0); // 13 latch latency
        v(1, 1, 0, 1, 0, 8'h02, 0, 8'h00, 8'h00, MR,       8'h0B, 1, 8'h00, 0, 8'd0); // held high
        v(1, 0, 0, 1, 0, 8'h00, 0, 8'h00, 8'h00, MR,       8'h0B, 1, 8'h00, 0, 8'd0);
        v(1, 1, 1, 1, 0, 8'h0B, 0, 8'h00, 8'h00, MR,       8'h00, 1, 8'h00, 0, 8'd0); // 16 write
        v(1, 0, 1, 0, 0, 8'h04, 1, 8'h05, 8'h55, MR|ML,    8'h00, 0, 8'h00, 0, 8'd0); // load stalls
        v(1, 0, 1, 0, 0, 8'h09, 1, 8'h05, 8'h55, MR|ML,    8'h00, 1, 8'h00, 0, 8'd0);
        v(1, 0, 0, 1, 0, 8'h00, 0, 8'h00, 8'h00, MR|ML,    8'h04, 1, 8'h00, 0, 8'd0);
        v(1, 1, 1, 1, 0, 8'h05, 0, 8'h00, 8'h00, MR,       8'h00, 1, 8'h00, 0, 8'd0);
        v(1, 0, 0, 1, 0, 8'h00, 0, 8'h00, 8'h00, MR,       8'h55, 1, 8'h00, 0, 8'd0);
        v(1, 1, 1, 0, 0, 8'h02, 0, 8'h00, 8'h00, MR|ML,    8'h00, 0, 8'h00, 0, 8'd0); // 22 latch+write
        v(1, 0, 0, 1, 0, 8'h00, 0, 8'h00, 8'h00, MR,       8'h14, 1, 8'h00, 0, 8'd0);
        v(1, 1, 1, 1, 0, 8'h05, 0, 8'h00, 8'h00, MR,       8'h00, 1, 8'h00, 0, 8'd0);
        v(1, 0, 0, 1, 0, 8'h00, 0, 8'h00, 8'h00, MR,       8'h02, 1, 8'h00, 0, 8'd0);
        v(1, 0, 0, 0, 0, 8'h66, 0, 8'h00, 8'h00, MR|ML,    8'h02, 0, 8'h00, 0, 8'd0); // 26 contention
        v(1, 0, 0, 1, 0, 8'h00, 0, 8'h00, 8'h00, MR,       8'h66, 1, 8'h00, 0, 8'd0);
        v(1, 0, 0, 1, 0, 8'h00, 1, 8'h05, 8'h77, MR|ML,    8'h66, 1, 8'h00, 0, 8'd0); // load vs read
        v(1, 0, 0, 1, 0, 8'h00, 0, 8'h00, 8'h00, MR,       8'h77, 1, 8'h00, 0, 8'd0);
        v(1, 0, 1, 1, 1, 8'h5A, 0, 8'h00, 8'h00, MO,       8'h00, 1, 8'h00, 0, 8'd0); // 30 output
        v(1, 0, 1, 1, 1, 8'h11, 0, 8'h00, 8'h00, MO,       8'h00, 1, 8'h5A, 1, 8'd1);
        v(1, 0, 1, 1, 1, 8'h11, 0, 8'h00, 8'h00, MO,       8'h00, 1, H5A,   0, 8'd1);
        v(1, 0, 1, 1, 0, 8'h11, 0, 8'h00, 8'h00, MO,       8'h00, 1, H5A,   0, 8'd1);
        v(1, 0, 1, 1, 1, 8'hA5, 0, 8'h00, 8'h00, MO,       8'h00, 1, H5A,   0, 8'd1);
        v(1, 0, 1, 1, 0, 8'h00, 0, 8'h00, 8'h00, MO,       8'h00, 1, 8'hA5, 1, 8'd2);
        v(1, 0, 1, 1, 0, 8'h00, 0, 8'h00, 8'h00, MO,       8'h00, 1, HA5,   0, 8'd2);
        v(0, 1, 0, 1, 1, 8'h01, 0, 8'h00, 8'h00, MR|MO,    8'h0A, 1, 8'h00, 0, 8'd0); // 37 mid-op reset
        v(0, 1, 0, 1, 1, 8'h01, 0, 8'h00, 8'h00, MR|MO,    8'h0A, 1, 8'h00, 0, 8'd0);
        v(1, 1, 0, 1, 1, 8'h01, 0, 8'h00, 8'h00, MR|MO,    8'h0A, 1, 8'h00, 0, 8'd0); // strobes high
        v(1, 1, 0, 1, 1, 8'h01, 0, 8'h00, 8'h00, MR|MO,    8'h0A, 1, 8'h00, 0, 8'd0);
        v(1, 0, 0, 1, 0, 8'h01, 0, 8'h00, 8'h00, MR|MO,    8'h0A, 1, 8'h00, 0, 8'd0);
        v(1, 1, 0, 1, 1, 8'h01, 0, 8'h00, 8'h00, MR|MO,    8'h0A, 1, 8'h00, 0, 8'd0);
        v(1, 0, 0, 1, 0, 8'h00, 0, 8'h00, 8'h00, MR|MO,    8'h0B, 1, 8'h01, 1, 8'd1);
        v(1, 0, 1, 1, 0, 8'h00, 0, 8'h00, 8'h00, MO,       8'h00, 1, H01,   0, 8'd1);

        out_ready = 1'b1;
        a4_lc = 1'b0; a4_oe = 1'b1; a4_we = 1'b1; a4_oc = 1'b0; a4_din = 8'h00;
        a4_lv = 1'b0; a4_la = 4'h0; a4_ld = 8'h00; a4_ordy = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            rst_n = tbl[i].rst; bus_latch_clk = tbl[i].lc; bus_oe = tbl[i].oe;
            bus_we = tbl[i].we; bus_out_clk = tbl[i].oc; bus_data_in = tbl[i].din;
            load_valid = tbl[i].lv; load_addr = tbl[i].la; load_data = tbl[i].ld;
            @(negedge clk);
            if (tbl[i].mask[0]) begin
                check($sformatf("v%0d_data_oe", i), {7'b0, bus_data_oe}, {7'b0, ~tbl[i].oe});
                check($sformatf("v%0d_data_out", i), bus_data_out, tbl[i].e_dout);
            end
            if (tbl[i].mask[1])
                check($sformatf("v%0d_load_ready", i), {7'b0, load_ready}, {7'b0, tbl[i].e_lr});
            if (tbl[i].mask[2]) begin
                check($sformatf("v%0d_out_data", i), out_data, tbl[i].e_od);
                check($sformatf("v%0d_out_valid", i), {7'b0, out_valid}, {7'b0, tbl[i].e_ov});
                check($sformatf("v%0d_out_count", i), out_count, tbl[i].e_oc);
            end
            tick();
        end

        // Narrow instance: address 0x13 must alias to mem[3].
        a4_lv = 1'b1; a4_la = 4'h3; a4_ld = 8'hC3;
        tick();
        a4_lv = 1'b0; a4_lc = 1'b1; a4_din = 8'h13;
        tick();
        a4_lc = 1'b0; a4_oe = 1'b0;
        @(negedge clk);
        check("aw4_read_alias", a4_dout, 8'hC3);
        tick();
        a4_oe = 1'b1; a4_we = 1'b0; a4_din = 8'h44;
        tick();
        a4_we = 1'b1; a4_lc = 1'b1; a4_din = 8'h03;
        tick();
        a4_lc = 1'b0; a4_oe = 1'b0;
        @(negedge clk);
        check("aw4_write_alias", a4_dout, 8'h44);
        tick();

`ifdef OUT_FIFO_EN
        // Fill past capacity with the consumer stalled, then drain.
        out_ready = 1'b0;
        for (int k = 1; k <= 5; k++) out_edge(8'(k));
        @(negedge clk);
        check("fifo_count_after_drop", out_count, 8'd6);
        check("fifo_head_valid", {7'b0, out_valid}, 8'd1);
        tick();
        out_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            check($sformatf("fifo_drain%0d", k), out_data, 8'(k));
            check($sformatf("fifo_drain%0d_valid", k), {7'b0, out_valid}, 8'd1);
            tick();
        end
        @(negedge clk);
        check("fifo_empty_after_drain", {7'b0, out_valid}, 8'd0);
        tick();
        // Full FIFO with simultaneous push and pop accepts the new byte.
        out_ready = 1'b0;
        for (int k = 1; k <= 4; k++) out_edge(8'(k));
        out_ready = 1'b1; bus_out_clk = 1'b1; bus_data_in = 8'h09;
        tick();
        bus_out_clk = 1'b0;
        for (int k = 0; k < 4; k++) begin
            logic [7:0] exp_b;
            exp_b = (k == 3) ? 8'h09 : 8'(k + 2);
            @(negedge clk);
            check($sformatf("fifo_full_pushpop%0d", k), out_data, exp_b);
            tick();
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
